// File: rtl/rvfi_bus_env_pkg.sv
// Shared types and helpers for the rvfi_bus_env formal bus environment.
package rvfi_bus_env_pkg;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} chk_state_t;

    localparam int MAX_AW = 64;

    // Stall counter width; at least one bit even when MAX_STALL is 0.
    function automatic int cnt_w(input int max_stall);
        int w;
        w = $clog2(max_stall + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Addresses compared at word granularity, ignoring the byte-offset bits.
    function automatic logic word_match(input logic [MAX_AW-1:0] a,
                                        input logic [MAX_AW-1:0] b,
                                        input int unsigned       lsb);
        return (a >> lsb) == (b >> lsb);
    endfunction

endpackage

// File: rtl/rvfi_bus_env_chan.sv
// One Wishbone-classic channel: bounded-latency ack generation and a
// sticky master-protocol checker.
module rvfi_bus_env_chan
    import rvfi_bus_env_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_STALL = 8,
    localparam int SW       = DW / 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_cyc,
    input  logic [AW-1:0] i_adr,
    input  logic          i_we,
    input  logic [SW-1:0] i_sel,
    input  logic [DW-1:0] i_dat,
    input  logic          i_any_ack,
    output logic          o_ack,
    output logic          o_proto_err
);
    localparam int CW = cnt_w(MAX_STALL);
    localparam logic [CW-1:0] C_SAT   = CW'(MAX_STALL);
    localparam logic [CW-1:0] C_FORCE = CW'((MAX_STALL == 0) ? 0 : MAX_STALL - 1);
    localparam logic          FORCE_EN = (MAX_STALL != 0);

    logic [CW-1:0] r_cnt;
    logic          r_ack_q;
    logic          w_force;

    assign w_force = FORCE_EN && (r_cnt == C_FORCE);
    assign o_ack   = r_ack_q && i_cyc && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt   <= '0;
            r_ack_q <= 1'b0;
        end else begin
            // Never ack twice in a row; force the ack once the wait hits the bound.
            r_ack_q <= i_cyc && !r_ack_q && (i_any_ack || w_force);
            if (!i_cyc || o_ack)
                r_cnt <= '0;
            else if (r_cnt != C_SAT)
                r_cnt <= r_cnt + CW'(1);
        end
    end

    chk_state_t    r_state, w_state_nxt;
    logic [AW-1:0] r_adr;
    logic          r_we;
    logic [SW-1:0] r_sel;
    logic [DW-1:0] r_dat;
    logic          r_err;
    logic          w_latch;
    logic          w_err_set;
    logic          w_diff;

    assign w_diff = (i_adr != r_adr) || (i_we != r_we) || (i_sel != r_sel) ||
                    (r_we && (i_dat != r_dat));

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_cyc && !o_ack) begin
                    w_latch     = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (!i_cyc) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_err_set = w_diff;
                    if (o_ack)
                        w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
            r_adr   <= '0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_dat   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_err_set)
                r_err <= 1'b1;
            if (w_latch) begin
                r_adr <= i_adr;
                r_we  <= i_we;
                r_sel <= i_sel;
                r_dat <= i_dat;
            end
        end
    end

    assign o_proto_err = r_err;

endmodule

// File: rtl/rvfi_bus_env.sv
// Formal-environment Wishbone-classic slave serving NCH independent buses.
// Optional build macro MEMIO_SHADOW_EN adds a single-word memory shadow.
module rvfi_bus_env
    import rvfi_bus_env_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_STALL = 8,
    localparam int SW       = DW / 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NCH-1:0]    i_cyc,
    input  logic [NCH*AW-1:0] i_adr,
    input  logic [NCH-1:0]    i_we,
    input  logic [NCH*SW-1:0] i_sel,
    input  logic [NCH*DW-1:0] i_dat,
    input  logic [NCH-1:0]    i_any_ack,
    input  logic [NCH*DW-1:0] i_any_rdt,
`ifdef MEMIO_SHADOW_EN
    input  logic [AW-1:0]     i_shadow_adr,
`endif
    output logic [NCH-1:0]    o_ack,
    output logic [NCH*DW-1:0] o_rdt,
    output logic [NCH-1:0]    o_proto_err
);
    logic [NCH-1:0]    w_ack;
    logic [NCH*DW-1:0] r_rdt;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        rvfi_bus_env_chan #(
            .AW        (AW),
            .DW        (DW),
            .MAX_STALL (MAX_STALL)
        ) u_chan (
            .clock       (clock),
            .reset       (reset),
            .i_cyc       (i_cyc[k]),
            .i_adr       (i_adr[k*AW +: AW]),
            .i_we        (i_we[k]),
            .i_sel       (i_sel[k*SW +: SW]),
            .i_dat       (i_dat[k*DW +: DW]),
            .i_any_ack   (i_any_ack[k]),
            .o_ack       (w_ack[k]),
            .o_proto_err (o_proto_err[k])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) r_rdt <= '0;
        else       r_rdt <= i_any_rdt;
    end

    assign o_ack = w_ack;

`ifdef MEMIO_SHADOW_EN
    localparam int unsigned LSB = $clog2(SW);

    logic [DW-1:0] r_sh_dat, w_sh_dat_nxt;
    logic [SW-1:0] r_sh_vld, w_sh_vld_nxt;
    logic [NCH-1:0] w_hit;

    always_comb begin
        for (int k = 0; k < NCH; k++)
            w_hit[k] = word_match(MAX_AW'(i_adr[k*AW +: AW]), MAX_AW'(i_shadow_adr), LSB);
    end

    // Ascending channel order lets the highest-indexed writer win each byte.
    always_comb begin
        w_sh_dat_nxt = r_sh_dat;
        w_sh_vld_nxt = r_sh_vld;
        for (int k = 0; k < NCH; k++) begin
            if (w_ack[k] && i_we[k] && w_hit[k]) begin
                for (int b = 0; b < SW; b++) begin
                    if (i_sel[k*SW + b]) begin
                        w_sh_dat_nxt[b*8 +: 8] = i_dat[k*DW + b*8 +: 8];
                        w_sh_vld_nxt[b]        = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sh_dat <= '0;
            r_sh_vld <= '0;
        end else begin
            r_sh_dat <= w_sh_dat_nxt;
            r_sh_vld <= w_sh_vld_nxt;
        end
    end

    // Reads see the registered shadow, i.e. the value before any same-cycle write.
    always_comb begin
        o_rdt = r_rdt;
        for (int k = 0; k < NCH; k++) begin
            if (w_ack[k] && !i_we[k] && w_hit[k]) begin
                for (int b = 0; b < SW; b++) begin
                    if (r_sh_vld[b])
                        o_rdt[k*DW + b*8 +: 8] = r_sh_dat[b*8 +: 8];
                end
            end
        end
    end
`else
    assign o_rdt = r_rdt;
`endif

endmodule
